spi_main: RTL and testbench

SPI_MAIN -- requirements
Module: spi_main

---
 rtl/spi_main.sv | 96 +++++++++
 tb/tb_spi_main.sv | 90 +++++++++
 2 files changed

// File: rtl/spi_main.sv
// spi_main: SPI master cycling each slave through KEY -> WRITE -> READ transactions.
// cs_n uses the literal encoding 2'b10 when slave 0 is selected and 2'b01 for slave 1.
module spi_main #(
  parameter int FRAME_KEY = 258,
  parameter int FRAME_BLK = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sel,
  input  logic [0:FRAME_KEY-1] tx,
  input  logic [0:1]           miso,
  output logic [0:FRAME_BLK-1] rx,
  output logic [0:1]           cs_n,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 done
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, FINISH} state_t;
  localparam logic [1:0] PH_KEY = 2'd0, PH_READ = 2'd2;
  localparam int PAD = FRAME_KEY - FRAME_BLK;
  state_t state, state_nx;
  logic [1:0] phase [0:1];
  logic [1:0] ph;
  logic sel_l;
  logic [0:FRAME_KEY-1] shreg;
  logic [0:FRAME_BLK-1] rxsr;
  logic [8:0] cnt, n_bits;
  logic more, load, rise, fall, fin;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  assign n_bits = (ph == PH_KEY) ? 9'(FRAME_KEY) : 9'(FRAME_BLK);
  assign more = cnt != n_bits;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? SETUP : IDLE;
      SETUP:    state_nx = SHIFT_HI;
      SHIFT_HI: state_nx = SHIFT_LO;
      SHIFT_LO: state_nx = more ? SHIFT_HI : FINISH;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    load = state == IDLE && start;
    rise = state == SETUP || (state == SHIFT_LO && more);
    fall = state == SHIFT_HI;
    fin  = state == SHIFT_LO && !more;
  end
  // Registered outputs and datapath, strobed by the FSM controls above.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cs_n <= 2'b11;
      sclk <= 1'b0;
      mosi <= 1'b0;
      done <= 1'b0;
      rx <= '0;
      rxsr <= '0;
      shreg <= '0;
      cnt <= '0;
      sel_l <= 1'b0;
      ph <= PH_KEY;
      phase[0] <= PH_KEY;
      phase[1] <= PH_KEY;
    end else begin
      if (load) begin
        sel_l <= sel;
        ph <= phase[sel];
        done <= 1'b0;
        cnt <= '0;
        cs_n <= sel ? 2'b01 : 2'b10;
        shreg <= (phase[sel] == PH_KEY) ? tx :
                 (phase[sel] == PH_READ) ? '0 : {tx[PAD:FRAME_KEY-1], {PAD{1'b0}}};
        mosi <= (phase[sel] == PH_KEY) ? tx[0] :
                (phase[sel] == PH_READ) ? 1'b0 : tx[PAD];
      end
      if (rise) begin
        sclk <= 1'b1;
        rxsr <= {rxsr[1:FRAME_BLK-1], miso[sel_l]};
      end
      if (fall) begin
        sclk <= 1'b0;
        mosi <= shreg[1];
        shreg <= shreg << 1;
        cnt <= cnt + 9'd1;
      end
      if (fin) begin
        cs_n <= 2'b11;
        mosi <= 1'b0;
        done <= 1'b1;
        if (ph == PH_READ) rx <= rxsr;
        phase[sel_l] <= (ph == PH_READ) ? PH_KEY : ph + 2'd1;
      end
    end
endmodule

// File: tb/tb_spi_main.sv
// tb_spi_main: directed checks of spi_main frames, phases, latency and reset abort.
module tb_spi_main;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
  logic [0:257] tx = '0;
  logic [0:1] miso = 2'b11;
  logic [0:127] rx;
  logic [0:1] cs_n;
  logic sclk, mosi, done;
  int n_assert = 0, n_fail = 0;
  spi_main dut (.clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .tx(tx), .miso(miso),
                .rx(rx), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .done(done));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic s, input logic [0:257] t, input logic [0:127] m,
                     input int n, input logic [0:257] e, input logic [0:1] cs_exp,
                     input logic [0:127] rx_exp, input int hold);
    int cyc, pulses, csbad, mosibad;
    logic prev;
    cyc = 0; pulses = 0; csbad = 0; mosibad = 0; prev = 1'b0;
    @(negedge clk);
    sel = s; tx = t; start = 1'b1; miso = 2'b11;
    while (cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold) start = 1'b0;
      if (cyc == 1) begin sel = ~s; tx = ~t; end
      if (done) break;
      if (cs_n !== cs_exp) csbad++;
      if (sclk && !prev) begin
        if (pulses < 258 && mosi !== e[pulses]) mosibad++;
        pulses++;
      end
      prev = sclk;
      if (!sclk) miso[s] = (pulses < 128) ? m[pulses] : 1'b0;
    end
    start = 1'b0;
    chk({tag, " latency"}, 256'(cyc - 1), 256'(2 * n + 1));
    chk({tag, " pulses"}, 256'(pulses), 256'(n));
    chk({tag, " cs_n during frame"}, 256'(csbad), 256'(0));
    chk({tag, " mosi bits"}, 256'(mosibad), 256'(0));
    chk({tag, " cs_n after"}, 256'(cs_n), 256'(2'b11));
    chk({tag, " rx"}, 256'(rx), 256'(rx_exp));
  endtask
  logic [0:257] key_tx, wr_tx, wr_exp;
  logic [0:127] blk, rd;
  initial begin
    key_tx = {2'b00, 128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    blk = 128'h00112233445566778899aabbccddeeff;
    wr_tx = {130'b0, blk};
    wr_exp = {blk, 130'b0};
    rd = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    #12;
    chk("reset cs_n", 256'(cs_n), 256'(2'b11));
    chk("reset sclk", 256'(sclk), 256'(0));
    chk("reset mosi", 256'(mosi), 256'(0));
    chk("reset done", 256'(done), 256'(0));
    chk("reset rx", 256'(rx), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run("key0", 1'b0, key_tx, '0, 258, key_tx, 2'b10, '0, 1);
    run("write0", 1'b0, wr_tx, '0, 128, wr_exp, 2'b10, '0, 1);
    run("read0", 1'b0, key_tx, rd, 128, '0, 2'b10, rd, 1);
    run("key1 held start", 1'b1, wr_exp, '0, 258, wr_exp, 2'b01, rd, 10);
    chk("done level", 256'(done), 256'(1));
    run("key0 again", 1'b0, wr_exp, '0, 258, wr_exp, 2'b10, rd, 1);
    @(negedge clk);
    sel = 1'b0; tx = wr_tx; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (121) @(negedge clk);
    chk("bit60 sclk high", 256'(sclk), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort cs_n", 256'(cs_n), 256'(2'b11));
    chk("abort sclk", 256'(sclk), 256'(0));
    chk("abort done", 256'(done), 256'(0));
    chk("abort rx", 256'(rx), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run("key after abort", 1'b0, key_tx, '0, 258, key_tx, 2'b10, '0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
